// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the EX-stage ALU arbiter: op encodings, FSM states and datapath width.
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: the requester that was not granted last wins a tie.
module rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_i,
  input  logic       accept_i,
  output logic [1:0] grant_o,
  output logic       last_o
);

  always_comb begin
    grant_o = 2'b00;
    last_o  = last_i;
    if (accept_i) begin
      if (valid0_i && valid1_i) begin
        grant_o = last_i ? 2'b01 : 2'b10;
      end else if (valid0_i) begin
        grant_o = 2'b01;
      end else if (valid1_i) begin
        grant_o = 2'b10;
      end
    end
    if (grant_o[1]) begin
      last_o = 1'b1;
    end else if (grant_o[0]) begin
      last_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbiter/sequencer for the shared EX-stage ALU: two requesters, one op in flight.
// Optional sticky overflow trap is enabled by defining ALU_ARBITER_OVF_TRAP_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// reqN_ready may depend combinationally on reqN_valid and on the response ready;
// rspN_valid and response fields are stable from assertion until the transfer.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ALU_W-1:0] req0_a,
  input  logic [ALU_W-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req0_is_sign,
  input  logic             req0_sign_rst,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ALU_W-1:0] req1_a,
  input  logic [ALU_W-1:0] req1_b,
  input  logic [3:0]       req1_op,
  input  logic             req1_is_sign,
  input  logic             req1_sign_rst,
  input  logic [TAG_W-1:0] req1_tag,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [ALU_W-1:0] rsp0_result,
  output logic             rsp0_overflow,
  output logic             rsp0_zero,
  output logic [TAG_W-1:0] rsp0_tag,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [ALU_W-1:0] rsp1_result,
  output logic             rsp1_overflow,
  output logic             rsp1_zero,
  output logic [TAG_W-1:0] rsp1_tag,

  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_is_sign,
  output logic             alu_sign_rst,
  input  logic [ALU_W-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_zero,

  output logic             ovf_trap,
  output logic [TAG_W-1:0] ovf_tag,
  input  logic             ovf_clr
);

  state_e           state_q;
  logic             last_q;
  logic             last_d;

  logic [ALU_W-1:0] a_q;
  logic [ALU_W-1:0] b_q;
  logic [3:0]       op_q;
  logic             is_sign_q;
  logic             sign_rst_q;
  logic [TAG_W-1:0] tag_q;
  logic             idx_q;

  logic [ALU_W-1:0] rsp_result_q;
  logic             rsp_overflow_q;
  logic             rsp_zero_q;
  logic [TAG_W-1:0] rsp_tag_q;

  logic             rsp_ready_sel;
  logic             accept;
  logic [1:0]       grant;
  logic             take;

  logic [ALU_W-1:0] a_d;
  logic [ALU_W-1:0] b_d;
  logic [3:0]       op_d;
  logic             is_sign_d;
  logic             sign_rst_d;
  logic [TAG_W-1:0] tag_d;

  assign rsp_ready_sel = idx_q ? rsp1_ready : rsp0_ready;

  // New requests are taken in IDLE or while the pending response drains;
  // reset gating keeps ready low even if a requester is already valid.
  assign accept = rst_n && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_sel));

  rr_arb2 u_rr_arb2 (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .last_i   (last_q),
    .accept_i (accept),
    .grant_o  (grant),
    .last_o   (last_d)
  );

  assign take       = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign a_d        = grant[1] ? req1_a        : req0_a;
  assign b_d        = grant[1] ? req1_b        : req0_b;
  assign op_d       = grant[1] ? req1_op       : req0_op;
  assign is_sign_d  = grant[1] ? req1_is_sign  : req0_is_sign;
  assign sign_rst_d = grant[1] ? req1_sign_rst : req0_sign_rst;
  assign tag_d      = grant[1] ? req1_tag      : req0_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      is_sign_q      <= 1'b0;
      sign_rst_q     <= 1'b0;
      tag_q          <= '0;
      idx_q          <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_tag_q      <= '0;
    end else begin
      last_q <= last_d;
      if (take) begin
        a_q        <= a_d;
        b_q        <= b_d;
        op_q       <= op_d;
        is_sign_q  <= is_sign_d;
        sign_rst_q <= sign_rst_d;
        tag_q      <= tag_d;
        idx_q      <= grant[1];
      end
      case (state_q)
        IDLE: begin
          if (take) begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q   <= alu_result;
          rsp_overflow_q <= alu_overflow;
          rsp_zero_q     <= alu_zero;
          rsp_tag_q      <= tag_q;
          state_q        <= RESP;
        end
        RESP: begin
          if (rsp_ready_sel) begin
            state_q <= take ? EXEC : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid    = (state_q == RESP) && !idx_q;
  assign rsp1_valid    = (state_q == RESP) &&  idx_q;
  assign rsp0_result   = rsp_result_q;
  assign rsp1_result   = rsp_result_q;
  assign rsp0_overflow = rsp_overflow_q;
  assign rsp1_overflow = rsp_overflow_q;
  assign rsp0_zero     = rsp_zero_q;
  assign rsp1_zero     = rsp_zero_q;
  assign rsp0_tag      = rsp_tag_q;
  assign rsp1_tag      = rsp_tag_q;

  // Flags are only meaningful while the ALU is actually evaluating our op.
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_op       = op_q;
  assign alu_is_sign  = is_sign_q;
  assign alu_sign_rst = (state_q == EXEC) ? sign_rst_q : 1'b1;

`ifdef ALU_ARBITER_OVF_TRAP_EN
  logic             trap_q;
  logic [TAG_W-1:0] trap_tag_q;
  logic             trap_set;

  assign trap_set = (state_q == EXEC) && is_sign_q && !sign_rst_q && alu_overflow;

  // Sticky: the first overflow's tag is kept until cleared; a clear in the
  // same cycle as a new overflow lets the new tag in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q     <= 1'b0;
      trap_tag_q <= '0;
    end else if (trap_set) begin
      trap_q <= 1'b1;
      if (!trap_q || ovf_clr) begin
        trap_tag_q <= tag_q;
      end
    end else if (ovf_clr) begin
      trap_q <= 1'b0;
    end
  end

  assign ovf_trap = trap_q;
  assign ovf_tag  = trap_tag_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_trap       = 1'b0;
  assign ovf_tag        = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the alu_* ports.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int TAG_W = 4;
`ifdef ALU_ARBITER_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req0_is_sign, req0_sign_rst;
  logic [31:0]      req0_a, req0_b;
  logic [3:0]       req0_op;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready, req1_is_sign, req1_sign_rst;
  logic [31:0]      req1_a, req1_b;
  logic [3:0]       req1_op;
  logic [TAG_W-1:0] req1_tag;
  logic             rsp0_valid, rsp0_ready, rsp0_overflow, rsp0_zero;
  logic [31:0]      rsp0_result;
  logic [TAG_W-1:0] rsp0_tag;
  logic             rsp1_valid, rsp1_ready, rsp1_overflow, rsp1_zero;
  logic [31:0]      rsp1_result;
  logic [TAG_W-1:0] rsp1_tag;
  logic [31:0]      alu_a, alu_b, alu_result;
  logic [3:0]       alu_op;
  logic             alu_is_sign, alu_sign_rst, alu_overflow, alu_zero;
  logic             ovf_trap, ovf_clr;
  logic [TAG_W-1:0] ovf_tag;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic             port;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [3:0]       op;
    logic             is_sign;
    logic             sign_rst;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic             ovf;
    logic             zero;
  } vec_t;

  vec_t vecs[13];
  logic [32:0] exp_q[$];

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_is_sign(req0_is_sign), .req0_sign_rst(req0_sign_rst), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_is_sign(req1_is_sign), .req1_sign_rst(req1_sign_rst), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_overflow(rsp0_overflow), .rsp0_zero(rsp0_zero), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_overflow(rsp1_overflow), .rsp1_zero(rsp1_zero), .rsp1_tag(rsp1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_is_sign(alu_is_sign),
    .alu_sign_rst(alu_sign_rst), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero),
    .ovf_trap(ovf_trap), .ovf_tag(ovf_tag), .ovf_clr(ovf_clr)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Behavioural shared ALU
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_NOR: alu_result = ~(alu_a | alu_b);
      ALU_SLT: alu_result = alu_is_sign ? {31'b0, $signed(alu_a) < $signed(alu_b)}
                                        : {31'b0, alu_a < alu_b};
      ALU_SLL: alu_result = alu_b << alu_a[4:0];
      ALU_SRL: alu_result = alu_b >> alu_a[4:0];
      ALU_SRA: alu_result = $unsigned($signed(alu_b) >>> alu_a[4:0]);
      default: alu_result = '0;
    endcase
    if (alu_is_sign && !alu_sign_rst) begin
      if (alu_op == ALU_ADD)
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      else if (alu_op == ALU_SUB)
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
    end
    alu_zero = !alu_sign_rst && (alu_result == 32'h0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver tasks
  task automatic drive(input vec_t v, input logic vld);
    if (v.port) begin
      req1_a = v.a; req1_b = v.b; req1_op = v.op; req1_is_sign = v.is_sign;
      req1_sign_rst = v.sign_rst; req1_tag = v.tag; req1_valid = vld;
    end else begin
      req0_a = v.a; req0_b = v.b; req0_op = v.op; req0_is_sign = v.is_sign;
      req0_sign_rst = v.sign_rst; req0_tag = v.tag; req0_valid = vld;
    end
  endtask

  task automatic apply_vec(input string nm, input vec_t v, input logic clr);
    @(negedge clk);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drive(v, 1'b1);
    #1;
    check({nm, "_ready"}, v.port ? req1_ready : req0_ready, 1);
    @(posedge clk); #1;
    drive(v, 1'b0);
    ovf_clr = clr;
    check({nm, "_exec_quiet"}, {rsp1_valid, rsp0_valid}, 0);
    check({nm, "_alu_sign_rst"}, alu_sign_rst, v.sign_rst);
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check({nm, "_valid"}, {rsp1_valid, rsp0_valid}, v.port ? 2'b10 : 2'b01);
    check({nm, "_result"}, v.port ? rsp1_result : rsp0_result, v.res);
    check({nm, "_ovf"}, v.port ? rsp1_overflow : rsp0_overflow, v.ovf);
    check({nm, "_zero"}, v.port ? rsp1_zero : rsp0_zero, v.zero);
    check({nm, "_tag"}, v.port ? rsp1_tag : rsp0_tag, v.tag);
    @(posedge clk); #1;
    check({nm, "_done"}, {rsp1_valid, rsp0_valid}, 0);
  endtask

  initial begin
    vec_t v;
    logic [32:0] exp;
    vecs[0]  = '{1'b0, 32'h7FFFFFFF, 32'h00000001, ALU_ADD, 1'b1, 1'b0, 4'd3, 32'h80000000, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 32'h00000005, 32'h00000005, ALU_SUB, 1'b1, 1'b0, 4'd5, 32'h00000000, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 32'h00000004, 32'h80000000, ALU_SRA, 1'b0, 1'b0, 4'd6, 32'hF8000000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h7FFFFFFF, 32'h00000001, ALU_ADD, 1'b1, 1'b1, 4'd1, 32'h80000000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h00000000, 32'h00000000, ALU_ADD, 1'b1, 1'b1, 4'd2, 32'h00000000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, ALU_AND, 1'b0, 1'b0, 4'd7, 32'h00F000F0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h00FF0000, 32'h0000FF00, ALU_OR,  1'b0, 1'b0, 4'd8, 32'h00FFFF00, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'hFFFF0000, 32'h0F0F0F0F, ALU_XOR, 1'b0, 1'b0, 4'd9, 32'hF0F00F0F, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h00000000, 32'h00000000, ALU_NOR, 1'b0, 1'b0, 4'd10, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'hFFFFFFFF, 32'h00000001, ALU_SLT, 1'b1, 1'b0, 4'd11, 32'h00000001, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h00000008, 32'h00000001, ALU_SLL, 1'b0, 1'b0, 4'd12, 32'h00000100, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'h00000004, 32'h80000000, ALU_SRL, 1'b0, 1'b0, 4'd13, 32'h08000000, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 32'h80000000, 32'h00000001, ALU_SUB, 1'b1, 1'b0, 4'd9, 32'h7FFFFFFF, 1'b1, 1'b0};

    // Reset with a requester already valid: ready must stay low.
    rst_n = 1'b0; ovf_clr = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    v = vecs[0]; v.port = 1'b0; drive(v, 1'b1);
    v.port = 1'b1; drive(v, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("rst_rsp_result", rsp0_result, 0);
    check("rst_rsp_flags", {rsp0_overflow, rsp0_zero, rsp1_overflow, rsp1_zero}, 0);
    check("rst_rsp_tag", rsp1_tag, 0);
    check("rst_alu_data", {alu_a, alu_b}, 0);
    check("rst_alu_sign_rst", alu_sign_rst, 1);
    check("rst_ovf", {ovf_trap, ovf_tag}, 0);
    req0_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Arbitration: both valid continuously, grants alternate starting at req0.
    @(negedge clk);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    v = '{1'b0, 32'd1, 32'd100, ALU_ADD, 1'b0, 1'b0, 4'd0, 32'd101, 1'b0, 1'b0}; drive(v, 1'b1);
    v = '{1'b1, 32'd2, 32'd200, ALU_ADD, 1'b0, 1'b0, 4'd1, 32'd202, 1'b0, 1'b0}; drive(v, 1'b1);
    exp_q.push_back({1'b0, 32'd101}); exp_q.push_back({1'b1, 32'd202});
    exp_q.push_back({1'b0, 32'd101}); exp_q.push_back({1'b1, 32'd202});
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("arb_onehot", rsp0_valid & rsp1_valid, 0);
      if (rsp0_valid || rsp1_valid) begin
        check("arb_cadence", c % 2, 1);
        if (exp_q.size() == 0) begin
          check("arb_extra_rsp", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check("arb_port", rsp1_valid, exp[32]);
          check("arb_result", rsp1_valid ? rsp1_result : rsp0_result, exp[31:0]);
        end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("arb_count", exp_q.size(), 0);
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      apply_vec($sformatf("vec%0d", i), vecs[i], 1'b0);
      if (i == 0) begin
        check("trap_first", ovf_trap, TRAP_EN);
        check("trap_first_tag", ovf_tag, TRAP_EN ? 3 : 0);
      end
    end
    check("trap_sticky", ovf_trap, TRAP_EN);
    check("trap_sticky_tag", ovf_tag, TRAP_EN ? 3 : 0);

    // Trap clear, re-arm, and clear colliding with a new overflow.
    @(negedge clk); ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    check("trap_clr", ovf_trap, 0);
    v = vecs[0]; v.tag = 4'd10;
    apply_vec("trap_rearm", v, 1'b0);
    check("trap_rearm", ovf_trap, TRAP_EN);
    check("trap_rearm_tag", ovf_tag, TRAP_EN ? 10 : 0);
    v.tag = 4'd11;
    apply_vec("trap_race", v, 1'b1);
    check("trap_race", ovf_trap, TRAP_EN);
    check("trap_race_tag", ovf_tag, TRAP_EN ? 11 : 0);

    // Backpressure on rsp0 with req1 pending.
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    v = '{1'b0, 32'd10, 32'd20, ALU_ADD, 1'b0, 1'b0, 4'd4, 32'd30, 1'b0, 1'b0}; drive(v, 1'b1);
    @(posedge clk); #1;
    drive(v, 1'b0);
    v = '{1'b1, 32'd3, 32'd5, ALU_XOR, 1'b0, 1'b0, 4'd8, 32'd6, 1'b0, 1'b0}; drive(v, 1'b1);
    check("bp_exec_ready1", req1_ready, 0);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", rsp0_valid, 1);
      check("bp_result", rsp0_result, 30);
      check("bp_tag", rsp0_tag, 4);
      check("bp_req_ready", {req1_ready, req0_ready}, 0);
    end
    rsp0_ready = 1'b1;
    #1;
    check("bp_release_ready1", req1_ready, 1);
    @(posedge clk); #1;
    drive(v, 1'b0);
    check("bp_rsp0_gone", {rsp1_valid, rsp0_valid}, 0);
    @(posedge clk); #1;
    check("bp_rsp1_valid", rsp1_valid, 1);
    check("bp_rsp1_result", rsp1_result, 6);
    check("bp_rsp1_tag", rsp1_tag, 8);
    @(posedge clk); #1;
    check("bp_done", {rsp1_valid, rsp0_valid}, 0);

    // Reset during EXEC of a req0 op (pointer now favours req1).
    @(negedge clk);
    v = '{1'b0, 32'h7FFFFFFF, 32'd1, ALU_ADD, 1'b1, 1'b0, 4'd12, 32'h80000000, 1'b1, 1'b0}; drive(v, 1'b1);
    @(posedge clk); #1;
    drive(v, 1'b0);
    v.port = 1'b1; drive(v, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("mid_rst_req_ready", {req1_ready, req0_ready}, 0);
    check("mid_rst_alu", {alu_a, alu_b}, 0);
    check("mid_rst_sign_rst", alu_sign_rst, 1);
    check("mid_rst_ovf", {ovf_trap, ovf_tag}, 0);
    drive(v, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", {rsp1_valid, rsp0_valid}, 0);
    end
    v = '{1'b0, 32'd7, 32'd8, ALU_ADD, 1'b0, 1'b0, 4'd1, 32'd15, 1'b0, 1'b0}; drive(v, 1'b1);
    v = '{1'b1, 32'd9, 32'd9, ALU_ADD, 1'b0, 1'b0, 4'd2, 32'd18, 1'b0, 1'b0}; drive(v, 1'b1);
    #1;
    check("post_rst_grant", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_rsp", {rsp1_valid, rsp0_valid}, 2'b01);
    check("post_rst_result", rsp0_result, 15);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
